mcu_upsample_buffer: RTL

Parametrised successor to the fixed 4:2:0 supersample buffer. It sits between the IDCT/level-shift stage and the colour converter. It collects one MCU of 8x8 blocks (Y blocks, then Cb, then Cr) and, for a run-time-selected subsampling mode (4:4:4, 4:2:2 or 4:2:0), emits one output beat per Y block. Each beat carries that Y block plus the matching nearest-neighbour-upsampled Cb/Cr 8x8 region. Both sides use valid/ready handshakes, so the colour converter can apply backpressure.

---
 rtl/mcu_upsample_buffer_if.sv | 28 ++
 rtl/mcu_upsample_buffer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mcu_upsample_buffer_if.sv
// Handshake and data bundle between the IDCT stage, the upsample buffer and the colour converter.
// The slave modport is the buffer's view; master is the surrounding pipeline's view.
interface mcu_upsample_buffer_if #(
  parameter int IN_W = 8,
  parameter int Q    = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic [1:0]                   ch_in;
  logic [7:0][7:0][IN_W-1:0]    block_in;
  logic                         out_valid;
  logic                         out_ready;
  logic [7:0][7:0][Q-1:0]       y_out;
  logic [7:0][7:0][Q-1:0]       cb_out;
  logic [7:0][7:0][Q-1:0]       cr_out;
  logic [1:0]                   blk_idx;
  logic                         last;

  modport slave (
    input  in_valid, ch_in, block_in, out_ready,
    output in_ready, out_valid, y_out, cb_out, cr_out, blk_idx, last
  );

  modport master (
    output in_valid, ch_in, block_in, out_ready,
    input  in_ready, out_valid, y_out, cb_out, cr_out, blk_idx, last
  );
endinterface

// File: rtl/mcu_upsample_buffer.sv
// Collects one MCU (Y blocks, Cb, Cr) and emits one beat per Y block with the
// nearest-neighbour-upsampled chroma region for 4:4:4, 4:2:2 or 4:2:0.

module mcu_chroma_map #(
  parameter int IN_W = 8,
  parameter int Q    = 8
) (
  input  logic [7:0][7:0][IN_W-1:0] din,
  input  logic [1:0]                mode,
  input  logic [1:0]                k,
  output logic [7:0][7:0][Q-1:0]    dout
);
  always_comb begin
    logic [2:0] sr, sc;
    dout = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        sr = 3'(r);
        sc = 3'(c);
        // k[0] picks the left/right half, k[1] the top/bottom half of the chroma block
        case (mode)
          2'd1: sc = {k[0], 2'(c >> 1)};
          2'd2: begin
            sr = {k[1], 2'(r >> 1)};
            sc = {k[0], 2'(c >> 1)};
          end
          default: ;
        endcase
        dout[r][c] = Q'(din[sr][sc]);
      end
    end
  end
endmodule

module mcu_upsample_buffer #(
  parameter int IN_W = 8,
  parameter int Q    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode,
  mcu_upsample_buffer_if.slave      bus,
  output logic                      err
);
  typedef enum logic [1:0] {COLLECT_Y, COLLECT_CB, COLLECT_CR, EMIT} state_e;
  typedef logic [7:0][7:0][IN_W-1:0] blk_t;

  state_e      state_q, state_d;
  logic [2:0]  y_cnt_q, y_cnt_d;
  logic [1:0]  emit_cnt_q, emit_cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic        err_q, err_d;
  blk_t [3:0]  y_q, y_d;
  blk_t        cb_q, cb_d, cr_q, cr_d;

  logic        accept, first_y;
  logic [2:0]  ny_eff, ny_lat;

  function automatic logic [2:0] ny_of(input logic [1:0] m);
    case (m)
      2'd0:    ny_of = 3'd1;
      2'd1:    ny_of = 3'd2;
      default: ny_of = 3'd4;
    endcase
  endfunction

  assign bus.in_ready  = (state_q != EMIT);
  assign bus.out_valid = (state_q == EMIT);
  assign accept        = bus.in_valid && bus.in_ready;
  assign first_y       = (state_q == COLLECT_Y) && (y_cnt_q == 3'd0);
  assign ny_lat        = ny_of(mode_q);
  // The first Y block of an MCU is judged against the mode it is about to latch
  assign ny_eff        = first_y ? ny_of(mode) : ny_lat;

  always_comb begin
    state_d    = state_q;
    y_cnt_d    = y_cnt_q;
    emit_cnt_d = emit_cnt_q;
    mode_d     = mode_q;
    err_d      = 1'b0;
    y_d        = y_q;
    cb_d       = cb_q;
    cr_d       = cr_q;
    unique case (state_q)
      COLLECT_Y: if (accept) begin
        if (bus.ch_in != 2'd0 || (first_y && mode == 2'd3)) begin
          err_d = 1'b1;
        end else begin
          y_d[y_cnt_q[1:0]] = bus.block_in;
          y_cnt_d           = y_cnt_q + 3'd1;
          if (first_y) mode_d = mode;
          if (y_cnt_q + 3'd1 == ny_eff) state_d = COLLECT_CB;
        end
      end
      COLLECT_CB: if (accept) begin
        if (bus.ch_in != 2'd1) begin
          err_d = 1'b1;
        end else begin
          cb_d    = bus.block_in;
          state_d = COLLECT_CR;
        end
      end
      COLLECT_CR: if (accept) begin
        if (bus.ch_in != 2'd2) begin
          err_d = 1'b1;
        end else begin
          cr_d       = bus.block_in;
          emit_cnt_d = 2'd0;
          state_d    = EMIT;
        end
      end
      EMIT: if (bus.out_ready) begin
        if ({1'b0, emit_cnt_q} == ny_lat - 3'd1) begin
          emit_cnt_d = 2'd0;
          y_cnt_d    = 3'd0;
          state_d    = COLLECT_Y;
        end else begin
          emit_cnt_d = emit_cnt_q + 2'd1;
        end
      end
      default: state_d = COLLECT_Y;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT_Y;
      y_cnt_q    <= '0;
      emit_cnt_q <= '0;
      mode_q     <= '0;
      err_q      <= 1'b0;
      y_q        <= '0;
      cb_q       <= '0;
      cr_q       <= '0;
    end else begin
      state_q    <= state_d;
      y_cnt_q    <= y_cnt_d;
      emit_cnt_q <= emit_cnt_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
      y_q        <= y_d;
      cb_q       <= cb_d;
      cr_q       <= cr_d;
    end
  end

  assign err         = err_q;
  assign bus.blk_idx = emit_cnt_q;
  assign bus.last    = (state_q == EMIT) && ({1'b0, emit_cnt_q} == ny_lat - 3'd1);

  logic [7:0][7:0][Q-1:0] y_ext;
  blk_t                   y_sel;
  assign y_sel = y_q[emit_cnt_q];

  always_comb begin
    y_ext = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        y_ext[r][c] = Q'(y_sel[r][c]);
  end
  assign bus.y_out = y_ext;

  blk_t [1:0]                   chroma;
  logic [1:0][7:0][7:0][Q-1:0]  chroma_out;
  assign chroma[0] = cb_q;
  assign chroma[1] = cr_q;

  for (genvar p = 0; p < 2; p++) begin : g_map
    mcu_chroma_map #(.IN_W(IN_W), .Q(Q)) u_map (
      .din  (chroma[p]),
      .mode (mode_q),
      .k    (emit_cnt_q),
      .dout (chroma_out[p])
    );
  end

  assign bus.cb_out = chroma_out[0];
  assign bus.cr_out = chroma_out[1];
endmodule
